// File: rtl/button_pkg.sv
// Shared types, width helper and default parameters for the push-button front end.
package button_pkg;

    typedef enum logic [1:0] {
        BTN_IDLE,
        BTN_PRESS,
        BTN_HOLD
    } btn_state_e;

    localparam int DEF_N_BTN        = 4;
    localparam int DEF_TICK_DIV     = 100_000;
    localparam int DEF_DB_SAMPLES   = 4;
    localparam int DEF_LONG_TICKS   = 1000;
    localparam int DEF_REPEAT_TICKS = 200;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-flop sync, tick-sampled debounce, press/hold FSM and
// registered one-clock event pulses.
module button_channel
    import button_pkg::*;
#(
    parameter int DB_SAMPLES   = DEF_DB_SAMPLES,
    parameter int LONG_TICKS   = DEF_LONG_TICKS,
    parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic btn,
    output logic btn_level,
    output logic btn_p_edge,
    output logic btn_n_edge,
    output logic short_press,
    output logic long_press,
    output logic repeat_press
);

    localparam int DBW = cnt_w(DB_SAMPLES);
    localparam int HW  = (cnt_w(LONG_TICKS) > cnt_w(REPEAT_TICKS)) ?
                         cnt_w(LONG_TICKS) : cnt_w(REPEAT_TICKS);
    localparam bit RPT_EN = (REPEAT_TICKS != 0);
    localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_SAMPLES - 1);
    localparam logic [HW-1:0]  LONG_LAST = HW'(LONG_TICKS - 1);
    localparam logic [HW-1:0]  RPT_LAST  = HW'(RPT_EN ? REPEAT_TICKS - 1 : 0);

    logic [1:0]     sync;
    logic [DBW-1:0] db_cnt;
    logic           differ, accept, rise, fall;
    btn_state_e     state, state_nx;
    logic [HW-1:0]  hold_cnt, hold_nx;
    logic           short_nx, long_nx, rpt_nx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync <= '0;
        else          sync <= {sync[0], btn};
    end

    // A level change is accepted on the tick that completes the run of differing samples.
    assign differ = sync[1] ^ btn_level;
    assign accept = tick && differ && (db_cnt == DB_LAST);
    assign rise   = accept && !btn_level;
    assign fall   = accept && btn_level;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_cnt     <= '0;
            btn_level  <= 1'b0;
            btn_p_edge <= 1'b0;
            btn_n_edge <= 1'b0;
        end else begin
            if (tick) db_cnt <= (differ && !accept) ? db_cnt + DBW'(1) : '0;
            btn_level  <= btn_level ^ accept;
            btn_p_edge <= rise;
            btn_n_edge <= fall;
        end
    end

    // A release on a threshold tick takes priority over the threshold pulse.
    always_comb begin
        state_nx = state;
        hold_nx  = hold_cnt;
        short_nx = 1'b0;
        long_nx  = 1'b0;
        rpt_nx   = 1'b0;
        case (state)
            BTN_IDLE: begin
                if (rise) begin
                    state_nx = BTN_PRESS;
                    hold_nx  = '0;
                end
            end
            BTN_PRESS: begin
                if (fall) begin
                    short_nx = 1'b1;
                    state_nx = BTN_IDLE;
                end else if (tick) begin
                    if (hold_cnt == LONG_LAST) begin
                        long_nx  = 1'b1;
                        state_nx = BTN_HOLD;
                        hold_nx  = '0;
                    end else begin
                        hold_nx = hold_cnt + HW'(1);
                    end
                end
            end
            BTN_HOLD: begin
                if (fall) begin
                    state_nx = BTN_IDLE;
                end else if (tick && RPT_EN) begin
                    if (hold_cnt == RPT_LAST) begin
                        rpt_nx  = 1'b1;
                        hold_nx = '0;
                    end else begin
                        hold_nx = hold_cnt + HW'(1);
                    end
                end
            end
            default: state_nx = BTN_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= BTN_IDLE;
            hold_cnt     <= '0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            repeat_press <= 1'b0;
        end else begin
            state        <= state_nx;
            hold_cnt     <= hold_nx;
            short_press  <= short_nx;
            long_press   <= long_nx;
            repeat_press <= rpt_nx;
        end
    end

endmodule

// File: rtl/button_array_cntr.sv
// Multi-channel button front end: shared sample-tick prescaler feeding an
// array of independent debounce/press-classification channels.
module button_array_cntr
    import button_pkg::*;
#(
    parameter int N_BTN        = DEF_N_BTN,
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int DB_SAMPLES   = DEF_DB_SAMPLES,
    parameter int LONG_TICKS   = DEF_LONG_TICKS,
    parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_p_edge,
    output logic [N_BTN-1:0] btn_n_edge,
    output logic [N_BTN-1:0] short_press,
    output logic [N_BTN-1:0] long_press,
    output logic [N_BTN-1:0] repeat_press
);

    localparam int TW = cnt_w(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0] div_cnt;
    logic          tick;

    assign tick = (div_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + TW'(1);
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        button_channel #(
            .DB_SAMPLES  (DB_SAMPLES),
            .LONG_TICKS  (LONG_TICKS),
            .REPEAT_TICKS(REPEAT_TICKS)
        ) u_ch (
            .clk         (clk),
            .reset_n     (reset_n),
            .tick        (tick),
            .btn         (btn[i]),
            .btn_level   (btn_level[i]),
            .btn_p_edge  (btn_p_edge[i]),
            .btn_n_edge  (btn_n_edge[i]),
            .short_press (short_press[i]),
            .long_press  (long_press[i]),
            .repeat_press(repeat_press[i])
        );
    end

endmodule

// File: tb/tb_button_array_cntr.sv
// Scoreboard bench: stimulus queues hand-computed pulse events (cycle, vector),
// a negedge monitor pops and compares whenever any pulse output is high.
module tb_button_array_cntr;

    localparam int N = 2;

    typedef struct {
        int         cyc;
        logic [9:0] vec;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] btn = '0;
    logic [N-1:0] level, pe, ne, sp, lp, rp;
    logic [N-1:0] nr_level, nr_pe, nr_ne, nr_sp, nr_lp, nr_rp;

    int   cyc;
    int   n_checks = 0;
    int   n_fail = 0;
    int   nr_long = 0;
    int   nr_rpt = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    button_array_cntr #(
        .N_BTN(N), .TICK_DIV(4), .DB_SAMPLES(3), .LONG_TICKS(5), .REPEAT_TICKS(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .btn(btn),
        .btn_level(level), .btn_p_edge(pe), .btn_n_edge(ne),
        .short_press(sp), .long_press(lp), .repeat_press(rp)
    );

    button_array_cntr #(
        .N_BTN(N), .TICK_DIV(4), .DB_SAMPLES(3), .LONG_TICKS(5), .REPEAT_TICKS(0)
    ) dut_nr (
        .clk(clk), .reset_n(reset_n), .btn(btn),
        .btn_level(nr_level), .btn_p_edge(nr_pe), .btn_n_edge(nr_ne),
        .short_press(nr_sp), .long_press(nr_lp), .repeat_press(nr_rp)
    );

    // cyc = number of posedges since reset release
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    // kind: 0 press edge, 1 release edge, 2 short, 3 long, 4 repeat
    function automatic logic [9:0] ev(input int kind, input int ch);
        logic [9:0] v;
        v = '0;
        v[kind*2+ch] = 1'b1;
        return v;
    endfunction

    task automatic push(input int c, input logic [9:0] v);
        exp_t e;
        e.cyc = c;
        e.vec = v;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    task automatic at(input int n);
        int guard;
        guard = 0;
        @(negedge clk);
        while (cyc != n && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_cycle: got %0d required %0d", cyc, n);
        end
    endtask

    always @(negedge clk) begin
        logic [9:0] v;
        exp_t       e;
        if (reset_n) begin
            v = {rp, lp, sp, ne, pe};
            nr_long += $countones(nr_lp);
            if (nr_rp != '0) nr_rpt++;
            if (v != '0) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pulse: cyc %0d got %b required none", cyc, v);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc != cyc || e.vec != v) begin
                        n_fail++;
                        $display("FAIL pulse_event: got cyc %0d vec %b required cyc %0d vec %b",
                                 cyc, v, e.cyc, e.vec);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        chk("reset_outputs", 32'({level, pe, ne, sp, lp, rp}), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // clean long hold on ch0 with repeats, plus a short glitch on ch1
        at(10);
        btn[0] = 1'b1;
        push(24, ev(0, 0));
        push(44, ev(3, 0));
        for (int k = 0; k < 5; k++) push(52 + 8 * k, ev(4, 0));
        push(88, ev(1, 0));
        at(30);
        chk("level_after_press", 32'(level), 32'b01);
        btn[1] = 1'b1;
        at(36);
        btn[1] = 1'b0;
        at(45);
        chk("level_after_glitch", 32'(level), 32'b01);
        at(76);
        btn[0] = 1'b0;
        at(90);
        chk("level_after_release", 32'(level), 32'b00);

        // short press
        at(100);
        btn[0] = 1'b1;
        push(112, ev(0, 0));
        push(124, ev(2, 0) | ev(1, 0));
        at(112);
        btn[0] = 1'b0;

        // both channels, debounced fall lands on the long threshold tick
        at(140);
        btn = 2'b11;
        push(152, ev(0, 0) | ev(0, 1));
        push(172, ev(2, 0) | ev(2, 1) | ev(1, 0) | ev(1, 1));
        at(160);
        chk("level_both", 32'(level), 32'b11);
        btn = 2'b00;

        // reset asserted in HOLD while a repeat pulse is high
        at(200);
        btn[0] = 1'b1;
        push(212, ev(0, 0));
        push(232, ev(3, 0));
        push(240, ev(4, 0));
        push(248, ev(4, 0));
        at(248);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", 32'({level, pe, ne, sp, lp, rp}), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // still held after reset release: debounced as a new press
        push(12, ev(0, 0));
        push(28, ev(2, 0) | ev(1, 0));
        at(14);
        btn[0] = 1'b0;
        at(40);
        chk("level_final", 32'(level), 32'b00);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        chk("no_repeat_when_disabled", 32'(nr_rpt), 32'd0);
        chk("long_count_no_repeat_dut", 32'(nr_long), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
